// File: rtl/la_pkg.sv
// Shared logic-analyzer types: capture FSM state encoding and default counter width.
package la_pkg;

  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for single-bit asynchronous analyzer inputs.
module bit_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  // Two-stage shift toward the i_clk domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/capture_sequencer.sv
// Capture run sequencer: start/trigger/run/drain/done FSM with a step prescaler
// and a saturating step counter; the limiter's stop flag ends the run.
module capture_sequencer
  import la_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             do_trigger,
  input  logic             i_trigger,
  input  logic [CNT_W-1:0] divider,
  input  logic             i_stop,
  output logic             o_run,
  output logic             o_step,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_step_count
);

  state_e           state_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] presc_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] presc_d;
  logic [CNT_W-1:0] count_d;
  logic             run_q;
  logic             step_q;
  logic             busy_q;
  logic             done_q;
  logic             stop_s;
  logic             wrap_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  bit_sync u_stop_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_stop),
    .o_q     (stop_s)
  );

  // Prescaler wrap detection and next values for the RUN datapath.
  always_comb begin
    wrap_s  = (presc_q == div_q);
    presc_d = wrap_s ? '0 : presc_q + CNT_W'(1);
    count_d = sat_inc(count_q);
  end

  // Capture FSM with registered outputs; abort overrides every other transition.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      presc_q <= '0;
      count_q <= '0;
      run_q   <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (i_abort) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            div_q   <= divider;
            presc_q <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            if (do_trigger) begin
              state_q <= ARMED;
            end else begin
              state_q <= RUN;
              run_q   <= 1'b1;
            end
          end
        end
        ARMED: begin
          if (i_trigger) begin
            state_q <= RUN;
            run_q   <= 1'b1;
            presc_q <= '0;
          end
        end
        RUN: begin
          // A stop seen on a wrap cycle wins, so that step is neither issued nor counted.
          if (stop_s) begin
            state_q <= DRAIN;
            run_q   <= 1'b0;
          end else begin
            presc_q <= presc_d;
            if (wrap_s) begin
              step_q  <= 1'b1;
              count_q <= count_d;
            end
          end
        end
        DRAIN: begin
          if (!stop_s) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          run_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_run        = run_q;
  assign o_step       = step_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_step_count = count_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: hand-computed cycle expectations per step.
module tb_capture_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, do_trig, trig, stop;
  logic [31:0] div;
  logic        run, step, busy, done;
  logic [31:0] cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  capture_sequencer #(.CNT_W(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .do_trigger   (do_trig),
    .i_trigger    (trig),
    .divider      (div),
    .i_stop       (stop),
    .o_run        (run),
    .o_step       (step),
    .o_busy       (busy),
    .o_done       (done),
    .o_step_count (cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; do_trig = 1'b0; trig = 1'b0; stop = 1'b0;
    div = 32'd0;
    tick(2);
    chk("rst_run", run, 1'b0);
    chk("rst_step", step, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cnt", cnt, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Run without trigger, divider 3: steps every 4 cycles, first at E4
    div = 32'd3; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("run_rise", run, 1'b1);
    chk("run_busy", busy, 1'b1);
    chk("run_cnt0", cnt, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      for (int j = 0; j < 3; j++) begin
        tick(1);
        chk("d3_nostep", step, 1'b0);
      end
      tick(1);
      chk("d3_step", step, 1'b1);
      chk("d3_cnt", cnt, 32'(k));
    end
    stop = 1'b1;
    tick(1); chk("stop_e1_run", run, 1'b1);
    tick(1); chk("stop_e2_run", run, 1'b1);
    tick(1); chk("stop_e3_run", run, 1'b0);
    chk("drain_busy", busy, 1'b1);
    chk("drain_step", step, 1'b0);
    stop = 1'b0;
    tick(1); chk("drain_nodone1", done, 1'b0);
    tick(1); chk("drain_nodone2", done, 1'b0);
    tick(1); chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b1);
    tick(1); chk("done_clear", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("final_cnt10", cnt, 32'd10);

    // Divider 0: step every RUN cycle, stop coincident with a wrap suppresses it
    div = 32'd0; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("d0_first_nostep", step, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      chk("d0_step", step, 1'b1);
      chk("d0_cnt", cnt, 32'(k));
    end
    stop = 1'b1;
    tick(2);
    chk("d0_step5", step, 1'b1);
    chk("d0_cnt5", cnt, 32'd5);
    tick(1);
    chk("d0_suppressed", step, 1'b0);
    chk("d0_run_low", run, 1'b0);
    chk("d0_cnt_hold", cnt, 32'd5);
    stop = 1'b0;
    tick(3); chk("d0_done", done, 1'b1);
    tick(1); chk("d0_idle", busy, 1'b0);

    // Triggered: armed for 20 cycles, run 1 edge after trigger
    div = 32'd1; do_trig = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("armed_run", run, 1'b0);
      chk("armed_busy", busy, 1'b1);
      tick(1);
    end
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    chk("trig_run", run, 1'b1);
    tick(1); chk("trig_nostep", step, 1'b0);
    tick(1); chk("trig_step", step, 1'b1);
    chk("trig_cnt", cnt, 32'd1);

    // Start while busy: ignored, divider not relatched, count kept
    div = 32'd7; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("busy_start_cnt", cnt, 32'd1);
    chk("busy_start_run", run, 1'b1);
    tick(1);
    chk("busy_start_step", step, 1'b1);
    chk("busy_start_cnt2", cnt, 32'd2);

    // Abort in RUN
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_run_run", run, 1'b0);
    chk("abort_run_busy", busy, 1'b0);
    chk("abort_run_done", done, 1'b0);
    tick(1);
    chk("abort_run_nodone", done, 1'b0);

    // Abort together with trigger in ARMED
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("armed2_busy", busy, 1'b1);
    abort = 1'b1; trig = 1'b1;
    tick(1);
    abort = 1'b0; trig = 1'b0;
    chk("abort_armed_run", run, 1'b0);
    chk("abort_armed_busy", busy, 1'b0);

    // Start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 1'b0);

    // Subsequent start accepted, count cleared
    do_trig = 1'b0; div = 32'd0; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("restart_run", run, 1'b1);
    chk("restart_cnt", cnt, 32'd0);

    // Abort in DRAIN
    stop = 1'b1;
    tick(3);
    chk("drain2_run", run, 1'b0);
    chk("drain2_busy", busy, 1'b1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    stop = 1'b0;
    chk("abort_drain_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_drain_nodone", done, 1'b0);
      tick(1);
    end

    // Asynchronous reset mid-RUN
    div = 32'd5; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    chk("d5_step", step, 1'b1);
    chk("d5_cnt", cnt, 32'd1);
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_run", run, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_cnt", cnt, 32'd0);
    chk("arst_step", step, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_busy", busy, 1'b0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("post_rst_start", run, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
